// File: rtl/sparc_mem_pkg.sv
// rtl/sparc_mem_pkg.sv - opcodes, FSM states and timeout default shared by mem_access_ctrl
package sparc_mem_pkg;

  localparam int TIMEOUT_DEF = 15;

  localparam logic [5:0] OP_LD   = 6'b001000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STD  = 6'b000111;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RELEASE, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE
  } size_e;

endpackage

// File: rtl/mem_op_decode.sv
// rtl/mem_op_decode.sv - opcode/alignment decode; ldd/std are legal only with LDD_STD_EN
module mem_op_decode
  import sparc_mem_pkg::*;
(
  input  logic [5:0] op,
  input  logic [2:0] addr,
  output size_e      size,
  output logic       is_load,
  output logic       is_double,
  output logic       legal
);

  logic known;
  logic aligned;

  always_comb begin
    size      = SZ_BYTE;
    is_load   = 1'b0;
    is_double = 1'b0;
    known     = 1'b1;
    aligned   = 1'b1;
    case (op)
      OP_LDUB, OP_LDSB: is_load = 1'b1;
      OP_STB:           size = SZ_BYTE;
      OP_LDUH, OP_LDSH: begin size = SZ_HALF; is_load = 1'b1; end
      OP_STH:           size = SZ_HALF;
      OP_LD:            begin size = SZ_WORD; is_load = 1'b1; end
      OP_ST:            size = SZ_WORD;
      OP_LDD, OP_STD: begin
`ifdef LDD_STD_EN
        size      = SZ_DOUBLE;
        is_double = 1'b1;
        is_load   = (op == OP_LDD);
`else
        known = 1'b0;
`endif
      end
      default: known = 1'b0;
    endcase
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~addr[0];
      SZ_WORD: aligned = (addr[1:0] == 2'b00);
      default: aligned = (addr == 3'b000);
    endcase
    legal = known & aligned;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - SPARC load/store sequencer driving an MFA/MFC handshake RAM
// LDD_STD_EN turns ldd/std into two back-to-back word accesses.
module mem_access_ctrl
  import sparc_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [5:0]  op,
  input  logic [8:0]  addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic        MFA,
  output logic [5:0]  opcode,
  output logic [8:0]  address,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut,
  input  logic        MFC
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [8:0]    addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          mfa_q, mfa_d;
  logic [5:0]    opcode_q, opcode_d;
  logic [8:0]    address_q, address_d;
  logic [31:0]   datain_q, datain_d;
  logic [63:0]   rdata_q, rdata_d;

  size_e dec_size;
  logic  dec_is_load, dec_is_double, dec_legal;

  mem_op_decode u_decode (
    .op        (op_q),
    .addr      (addr_q[2:0]),
    .size      (dec_size),
    .is_load   (dec_is_load),
    .is_double (dec_is_double),
    .legal     (dec_legal)
  );

  logic timeout, second_pend, abort;
  assign timeout     = (cnt_q == CW'(TIMEOUT - 1));
  assign second_pend = (dec_size == SZ_DOUBLE) && !word_q;
  assign abort       = timeout && (((state_q == S_WAIT) && !MFC) ||
                                   ((state_q == S_RELEASE) && MFC));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req) state_d = S_CHECK;
      S_CHECK:   state_d = dec_legal ? S_ISSUE : S_DONE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT:    if (MFC) state_d = S_RELEASE;
                 else if (timeout) state_d = S_DONE;
      S_RELEASE: if (!MFC) state_d = second_pend ? S_ISSUE : S_DONE;
                 else if (timeout) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Command registers load on the edge that enters ISSUE so MFA rises with ISSUE itself.
  always_comb begin
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    mfa_d     = mfa_q;
    opcode_d  = opcode_q;
    address_d = address_q;
    datain_d  = datain_q;
    rdata_d   = rdata_q;
    if (state_q == S_IDLE && req) begin
      op_d    = op;
      addr_d  = addr;
      wdata_d = wdata;
      err_d   = 1'b0;
      word_d  = 1'b0;
    end
    if (state_q == S_CHECK && !dec_legal) err_d = 1'b1;
    if (state_q == S_WAIT || state_q == S_RELEASE) cnt_d = cnt_q + 1'b1;
    if (state_q == S_WAIT && MFC) begin
      mfa_d = 1'b0;
      if (dec_is_load) begin
`ifdef LDD_STD_EN
        if (word_q) rdata_d[63:32] = DataOut;
        else        rdata_d[31:0]  = DataOut;
`else
        rdata_d[31:0] = DataOut;
`endif
      end
    end
    if (abort) begin
      err_d = 1'b1;
      mfa_d = 1'b0;
    end
    if (state_d == S_ISSUE) begin
      mfa_d    = 1'b1;
      cnt_d    = '0;
      opcode_d = dec_is_double ? (dec_is_load ? OP_LD : OP_ST) : op_q;
      if (state_q == S_RELEASE) begin
        word_d    = 1'b1;
        address_d = addr_q + 9'd4;
        datain_d  = wdata_q[63:32];
      end else begin
        address_d = addr_q;
        datain_d  = wdata_q[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      word_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      mfa_q     <= 1'b0;
      opcode_q  <= '0;
      address_q <= '0;
      datain_q  <= '0;
      rdata_q   <= '0;
    end else begin
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      mfa_q     <= mfa_d;
      opcode_q  <= opcode_d;
      address_q <= address_d;
      datain_q  <= datain_d;
      rdata_q   <= rdata_d;
    end
  end

  assign err     = err_q;
  assign MFA     = mfa_q;
  assign opcode  = opcode_q;
  assign address = address_q;
  assign DataIn  = datain_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

`ifdef LDD_STD_EN
  localparam bit DBL_OK = 1'b1;
`else
  localparam bit DBL_OK = 1'b0;
`endif

  localparam logic [5:0] T_LD = 6'b001000, T_LDUB = 6'b000001, T_LDUH = 6'b000010;
  localparam logic [5:0] T_LDSB = 6'b001001, T_LDSH = 6'b001010, T_LDD = 6'b000011;
  localparam logic [5:0] T_STB = 6'b000101, T_STH = 6'b000110, T_ST = 6'b000100;
  localparam logic [5:0] T_STD = 6'b000111;

  logic        clk = 1'b0;
  logic        reset, req;
  logic [5:0]  op;
  logic [8:0]  addr;
  logic [63:0] wdata;
  logic        busy, done, err;
  logic [63:0] rdata;
  logic        MFA, MFC;
  logic [5:0]  opcode;
  logic [8:0]  address;
  logic [31:0] DataIn, DataOut;

  logic        mfc_en;
  logic [31:0] ram     [128];
  logic [31:0] ref_mem [128];
  logic [63:0] exp_rdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .MFA(MFA),
    .opcode(opcode), .address(address), .DataIn(DataIn),
    .DataOut(DataOut), .MFC(MFC)
  );

  always #5 clk = ~clk;

  // RAM that answers in zero time: MFC follows MFA combinationally.
  assign MFC     = MFA & mfc_en;
  assign DataOut = ram[address[8:2]];
  always @(posedge clk) if (MFA && MFC && opcode == T_ST) ram[address[8:2]] = DataIn;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int op_bytes(input logic [5:0] o);
    case (o)
      T_LDUB, T_LDSB, T_STB: return 1;
      T_LDUH, T_LDSH, T_STH: return 2;
      T_LD, T_ST:            return 4;
      T_LDD, T_STD:          return DBL_OK ? 8 : 0;
      default:               return 0;
    endcase
  endfunction

  function automatic bit op_is_load(input logic [5:0] o);
    return o == T_LD || o == T_LDUB || o == T_LDUH || o == T_LDSB || o == T_LDSH || o == T_LDD;
  endfunction

  task automatic run(input logic [5:0] o, input logic [8:0] a, input logic [63:0] w,
                     input bit stuck, input bit hold);
    int          nb     = op_bytes(o);
    bit          legal  = (nb != 0) && ((int'(a) % nb) == 0);
    int          words  = (nb == 8) ? 2 : 1;
    bit          ld     = op_is_load(o);
    bit          exp_err;
    int          exp_pulses, exp_done;
    int          k, pulses, first_mfa;
    bit          prev_mfa, busy_ok;
    logic [8:0]  rec_addr [2];
    logic [5:0]  rec_op   [2];
    logic [31:0] rec_di   [2];

    if (!legal) begin
      exp_err = 1'b1; exp_pulses = 0; exp_done = 2;
    end else if (stuck) begin
      exp_err = 1'b1; exp_pulses = 1; exp_done = 18;
    end else begin
      exp_err = 1'b0; exp_pulses = words; exp_done = (words == 2) ? 8 : 5;
      for (int i = 0; i < words; i++) begin
        int wa = ((int'(a) + 4 * i) % 512) / 4;
        if (ld) begin
          if (i == 0) exp_rdata[31:0] = ref_mem[wa];
          else        exp_rdata[63:32] = ref_mem[wa];
        end else if (o == T_ST || o == T_STD) begin
          ref_mem[wa] = (i == 0) ? w[31:0] : w[63:32];
        end
      end
    end

    mfc_en = !stuck;
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = w;
    @(posedge clk); #1;
    k = 1; pulses = 0; first_mfa = -1; prev_mfa = 1'b0; busy_ok = 1'b1;
    forever begin
      if (MFA && !prev_mfa) begin
        if (pulses < 2) begin
          rec_addr[pulses] = address; rec_op[pulses] = opcode; rec_di[pulses] = DataIn;
        end
        if (pulses == 0) first_mfa = k;
        pulses++;
      end
      prev_mfa = MFA;
      if (!busy) busy_ok = 1'b0;
      if (done || k >= 40) break;
      if (hold && k == 1) op = 6'b111111;
      if (k == (hold ? 3 : 1)) req = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    req = 1'b0;

    check("done_seen", done, 1'b1);
    if (stuck && legal) check("timeout_cycle", (k >= 17 && k <= 18), 1'b1);
    else                check("done_cycle", k, exp_done);
    check("err", err, exp_err);
    check("mfa_low_at_done", MFA, 1'b0);
    check("busy_while_active", busy_ok, 1'b1);
    check("mfa_pulses", pulses, exp_pulses);
    if (exp_pulses > 0) check("first_mfa_cycle", first_mfa, 2);
    for (int i = 0; i < exp_pulses && i < pulses; i++) begin
      check("ram_address", rec_addr[i], 9'((int'(a) + 4 * i) % 512));
      check("ram_opcode", rec_op[i], (words == 2) ? (ld ? T_LD : T_ST) : o);
      if (!ld) check("ram_datain", rec_di[i], (i == 0) ? w[31:0] : w[63:32]);
    end
    check("rdata", rdata, exp_rdata);

    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_not_busy", busy, 1'b0);
    check("err_hold", err, exp_err);
    check("rdata_hold", rdata, exp_rdata);
  endtask

  logic [5:0] op_tab [12];

  initial begin
    int  k;
    bit  saw_done;
    op_tab = '{T_LD, T_LDUB, T_LDUH, T_LDSB, T_LDSH, T_LDD,
               T_STB, T_STH, T_ST, T_STD, 6'b111111, 6'b010000};
    for (int i = 0; i < 128; i++) begin
      logic [31:0] v = $urandom;
      ram[i] = v; ref_mem[i] = v;
    end
    reset = 1'b1; req = 1'b0; op = '0; addr = '0; wdata = '0; mfc_en = 1'b1;
    exp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mfa", MFA, 1'b0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_opcode", opcode, 6'd0);
    check("rst_address", address, 9'd0);
    check("rst_datain", DataIn, 32'd0);
    @(negedge clk); reset = 1'b0;

    run(T_ST, 9'h010, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
    run(T_LD, 9'h010, 64'h0, 1'b0, 1'b0);
    check("ld_deadbeef", rdata[31:0], 32'hDEAD_BEEF);
    run(T_LDSH, 9'h003, 64'h0, 1'b0, 1'b0);
    run(T_LDSH, 9'h002, 64'h0, 1'b0, 1'b0);
    run(T_STD, 9'h1F8, 64'h1111_1111_2222_2222, 1'b0, 1'b0);
    run(T_LDD, 9'h1F8, 64'h0, 1'b0, 1'b0);
    if (DBL_OK) check("ldd_value", rdata, 64'h1111_1111_2222_2222);
    run(T_LD, 9'h040, 64'h0, 1'b1, 1'b0);
    run(T_ST, 9'h044, 64'h0000_0000_1234_5678, 1'b0, 1'b1);

    // Reset while waiting on a stuck RAM.
    mfc_en = 1'b0;
    @(negedge clk); req = 1'b1; op = T_LD; addr = 9'h020;
    @(posedge clk); #1; req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_mfa_before", MFA, 1'b1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_mfa", MFA, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    @(negedge clk); reset = 1'b0; mfc_en = 1'b1;
    exp_rdata = '0;
    saw_done = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("rst_mid_no_done", saw_done, 1'b0);
    run(T_LD, 9'h010, 64'h0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [5:0]  o = op_tab[$urandom_range(0, 11)];
      logic [8:0]  a = 9'($urandom_range(0, 511));
      logic [63:0] w = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a = a & 9'h1F8;
      run(o, a, w, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
